// File: rtl/idli_sqi_resp_pkg.sv
// ============================================================================
// Module      : idli_sqi_resp_pkg
// Description : Shared state encoding and command opcodes for the SQI responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package idli_sqi_resp_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        ADDR    = 3'd2,
        DUMMY   = 3'd3,
        RD_DATA = 3'd4,
        WR_DATA = 3'd5,
        IGNORE  = 3'd6
    } idli_pkg_resp_state_t;

    localparam logic [7:0] SQI_CMD_READ  = 8'h03;
    localparam logic [7:0] SQI_CMD_WRITE = 8'h02;

    // Nibble counter width; covers the address and dummy phases.
    localparam int SQI_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/idli_sqi_edge_m.sv
// ============================================================================
// Module      : idli_sqi_edge_m
// Description : Registers the SQI clock and produces single-cycle rise/fall pulses.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module idli_sqi_edge_m (
    input  logic i_edge_clk,
    input  logic i_edge_rst,
    input  logic i_edge_sck,
    output logic o_edge_rise,
    output logic o_edge_fall
);

    logic sck_q;

    always_ff @(posedge i_edge_clk or posedge i_edge_rst) begin
        if (i_edge_rst) begin
            sck_q <= 1'b0;
        end else begin
            sck_q <= i_edge_sck;
        end
    end

    assign o_edge_rise = i_edge_sck & ~sck_q;
    assign o_edge_fall = ~i_edge_sck & sck_q;

endmodule

`default_nettype wire

// File: rtl/idli_sqi_resp_m.sv
// ============================================================================
// Module      : idli_sqi_resp_m
// Description : SQI responder; decodes read/write commands and bridges them to
//               a single-port byte memory with 1-cycle read latency.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module idli_sqi_resp_m
    import idli_sqi_resp_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DUMMY_NIB = 2
) (
    input  logic              i_resp_gck,
    input  logic              i_resp_rst,
    input  logic              i_resp_sqi_sck,
    input  logic              i_resp_sqi_cs,
    input  logic              i_resp_sqi_mode,
    input  logic [3:0]        i_resp_sqi_data,
    output logic [3:0]        o_resp_sqi_data,
    output logic              o_resp_sqi_oe,
    output logic              o_resp_mem_rd,
    output logic              o_resp_mem_wr,
    output logic [ADDR_W-1:0] o_resp_mem_addr,
    output logic [7:0]        o_resp_mem_wr_data,
    input  logic [7:0]        i_resp_mem_rd_data
);

    localparam logic [SQI_CNT_W-1:0] c_addr_last  = SQI_CNT_W'(ADDR_W / 4 - 1);
    localparam logic [SQI_CNT_W-1:0] c_dummy_last = SQI_CNT_W'(DUMMY_NIB - 1);
    localparam logic [ADDR_W-1:0]    c_addr_one   = ADDR_W'(1);

    idli_pkg_resp_state_t state_q, state_d;
    logic [SQI_CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]           cmd_hi_q, cmd_hi_d;
    logic                 is_wr_q, is_wr_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [7:0]           buf_q, buf_d;
    logic [3:0]           wr_hi_q, wr_hi_d;
    logic                 phase_q, phase_d;
    logic [3:0]           data_q, data_d;
    logic                 oe_q, oe_d;
    logic                 rd_q, rd_d;
    logic                 wr_q, wr_d;
    logic                 pend_q, pend_d;
    logic [ADDR_W-1:0]    maddr_q, maddr_d;
    logic [7:0]           wdata_q, wdata_d;

    logic                 w_rise;
    logic                 w_fall;
    logic [7:0]           w_cmd;

    idli_sqi_edge_m u_edge (
        .i_edge_clk  (i_resp_gck),
        .i_edge_rst  (i_resp_rst),
        .i_edge_sck  (i_resp_sqi_sck),
        .o_edge_rise (w_rise),
        .o_edge_fall (w_fall)
    );

    assign w_cmd = {cmd_hi_q, i_resp_sqi_data};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cmd_hi_d = cmd_hi_q;
        is_wr_d  = is_wr_q;
        addr_d   = addr_q;
        buf_d    = buf_q;
        wr_hi_d  = wr_hi_q;
        phase_d  = phase_q;
        data_d   = data_q;
        oe_d     = oe_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        maddr_d  = maddr_q;
        wdata_d  = wdata_q;
        pend_d   = rd_q;

        // Memory answers one cycle after the strobe is seen.
        if (pend_q) begin
            buf_d = i_resp_mem_rd_data;
        end

        if (i_resp_sqi_cs) begin
            state_d = IDLE;
            cnt_d   = '0;
            phase_d = 1'b0;
            oe_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = CMD;
                    cnt_d   = '0;
                end
                CMD: begin
                    if (w_rise) begin
                        cmd_hi_d = i_resp_sqi_data;
                        cnt_d    = cnt_q + 1'b1;
                        if (cnt_q == SQI_CNT_W'(1)) begin
                            cnt_d = '0;
                            if (w_cmd == SQI_CMD_READ) begin
                                state_d = ADDR;
                                is_wr_d = 1'b0;
                            end else if (w_cmd == SQI_CMD_WRITE) begin
                                state_d = ADDR;
                                is_wr_d = 1'b1;
                            end else begin
                                state_d = IGNORE;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (w_rise) begin
                        addr_d = {addr_q[ADDR_W-5:0], i_resp_sqi_data};
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == c_addr_last) begin
                            cnt_d   = '0;
                            phase_d = 1'b0;
                            state_d = is_wr_q ? WR_DATA : DUMMY;
                        end
                    end
                end
                DUMMY: begin
                    if (w_rise) begin
                        if (cnt_q == '0) begin
                            rd_d    = 1'b1;
                            maddr_d = addr_q;
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == c_dummy_last) begin
                            cnt_d   = '0;
                            phase_d = 1'b0;
                            state_d = RD_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (w_fall) begin
                        oe_d = i_resp_sqi_mode;
                        if (!phase_q) begin
                            data_d  = buf_q[7:4];
                            phase_d = 1'b1;
                        end else begin
                            // Low nibble out: prefetch the next byte in time for the next fall.
                            data_d  = buf_q[3:0];
                            phase_d = 1'b0;
                            addr_d  = addr_q + c_addr_one;
                            maddr_d = addr_q + c_addr_one;
                            rd_d    = 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (w_rise) begin
                        if (!phase_q) begin
                            wr_hi_d = i_resp_sqi_data;
                            phase_d = 1'b1;
                        end else begin
                            wr_d    = 1'b1;
                            maddr_d = addr_q;
                            wdata_d = {wr_hi_q, i_resp_sqi_data};
                            addr_d  = addr_q + c_addr_one;
                            phase_d = 1'b0;
                        end
                    end
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_resp_gck or posedge i_resp_rst) begin
        if (i_resp_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            cmd_hi_q <= '0;
            is_wr_q  <= 1'b0;
            addr_q   <= '0;
            buf_q    <= '0;
            wr_hi_q  <= '0;
            phase_q  <= 1'b0;
            data_q   <= '0;
            oe_q     <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            pend_q   <= 1'b0;
            maddr_q  <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            cmd_hi_q <= cmd_hi_d;
            is_wr_q  <= is_wr_d;
            addr_q   <= addr_d;
            buf_q    <= buf_d;
            wr_hi_q  <= wr_hi_d;
            phase_q  <= phase_d;
            data_q   <= data_d;
            oe_q     <= oe_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            pend_q   <= pend_d;
            maddr_q  <= maddr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign o_resp_sqi_data    = data_q;
    assign o_resp_sqi_oe      = oe_q;
    assign o_resp_mem_rd      = rd_q;
    assign o_resp_mem_wr      = wr_q;
    assign o_resp_mem_addr    = maddr_q;
    assign o_resp_mem_wr_data = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_idli_sqi_resp_m.sv
// ============================================================================
// Module      : tb_idli_sqi_resp_m
// Description : Randomized self-checking bench for the SQI responder.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_idli_sqi_resp_m;

    localparam int ADDR_W    = 16;
    localparam int DUMMY_NIB = 2;

    typedef struct packed {
        logic        wr;
        logic [15:0] a;
        logic [7:0]  d;
    } ev_t;

    logic        clk  = 1'b0;
    logic        rst  = 1'b1;
    logic        sck  = 1'b0;
    logic        cs   = 1'b1;
    logic        mode = 1'b0;
    logic [3:0]  din  = 4'h0;
    logic [3:0]  dout;
    logic        oe;
    logic        mrd;
    logic        mwr;
    logic [15:0] maddr;
    logic [7:0]  mwdata;
    logic [7:0]  mrdata = 8'h00;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    ev_t         exp_q [$];
    logic [3:0]  got_q [$];
    logic [7:0]  wq    [$];

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    bit oe_allowed = 1'b0;
    bit mon_on     = 1'b0;

    idli_sqi_resp_m #(
        .ADDR_W    (ADDR_W),
        .DUMMY_NIB (DUMMY_NIB)
    ) dut (
        .i_resp_gck         (clk),
        .i_resp_rst         (rst),
        .i_resp_sqi_sck     (sck),
        .i_resp_sqi_cs      (cs),
        .i_resp_sqi_mode    (mode),
        .i_resp_sqi_data    (din),
        .o_resp_sqi_data    (dout),
        .o_resp_sqi_oe      (oe),
        .o_resp_mem_rd      (mrd),
        .o_resp_mem_wr      (mwr),
        .o_resp_mem_addr    (maddr),
        .o_resp_mem_wr_data (mwdata),
        .i_resp_mem_rd_data (mrdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic hold();
        repeat ($urandom_range(2, 4)) @(posedge clk);
        #1;
    endtask

    task automatic nib(input logic [3:0] n);
        din = n;
        hold();
        sck = 1'b1;
        hold();
        sck = 1'b0;
    endtask

    task automatic send_cmd_addr(input logic [7:0] c, input logic [15:0] a);
        cs = 1'b0;
        hold();
        nib(c[7:4]);
        nib(c[3:0]);
        for (int k = 3; k >= 0; k--) nib(a[4*k +: 4]);
    endtask

    task automatic end_txn();
        hold();
        cs = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        oe_allowed = 1'b0;
        mode = 1'b0;
        sck = 1'b0;
        hold();
        check("pending_strobes", 32'(exp_q.size()), 32'd0);
    endtask

    // Initiator reads n bytes from a; the responder prefetches one byte beyond the last.
    task automatic do_read(input logic [15:0] a, input int n, input logic md, input bit rst_mid);
        logic [15:0] ai;
        got_q.delete();
        send_cmd_addr(8'h03, a);
        mode = md;
        for (int d = 0; d < DUMMY_NIB; d++) begin
            din = 4'($urandom);
            hold();
            if (d == 0) exp_q.push_back(ev_t'({1'b0, a, 8'h00}));
            sck = 1'b1;
            hold();
            if (d == DUMMY_NIB - 1) oe_allowed = md;
            sck = 1'b0;
        end
        for (int i = 0; i < n; i++) begin
            ai = a + 16'(i);
            hold();
            sck = 1'b1;
            check("rd_hi", 32'(dout), 32'(ref_mem[ai][7:4]));
            check("rd_oe", 32'(oe), 32'(md));
            got_q.push_back(dout);
            if (rst_mid) begin
                #2 rst = 1'b1;
                #1;
                check("rst_oe", 32'(oe), 32'd0);
                check("rst_data", 32'(dout), 32'd0);
                check("rst_strobes", 32'({mrd, mwr}), 32'd0);
                cs = 1'b1;
                sck = 1'b0;
                mode = 1'b0;
                oe_allowed = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                hold();
                check("rst_pending", 32'(exp_q.size()), 32'd0);
                return;
            end
            hold();
            exp_q.push_back(ev_t'({1'b0, 16'(ai + 16'd1), 8'h00}));
            sck = 1'b0;
            hold();
            sck = 1'b1;
            check("rd_lo", 32'(dout), 32'(ref_mem[ai][3:0]));
            check("rd_oe", 32'(oe), 32'(md));
            got_q.push_back(dout);
            if (i != n - 1) begin
                hold();
                sck = 1'b0;
            end
        end
        end_txn();
    endtask

    // Writes the bytes queued in wq; partial adds one dangling nibble before cs rises.
    task automatic do_write(input logic [15:0] a, input bit partial);
        logic [7:0]  b;
        logic [15:0] ai;
        int          n;
        n = wq.size();
        send_cmd_addr(8'h02, a);
        for (int i = 0; i < n; i++) begin
            b  = wq.pop_front();
            ai = a + 16'(i);
            nib(b[7:4]);
            din = b[3:0];
            hold();
            exp_q.push_back(ev_t'({1'b1, ai, b}));
            ref_mem[ai] = b;
            sck = 1'b1;
            hold();
            sck = 1'b0;
        end
        if (partial) nib(4'($urandom));
        end_txn();
    endtask

    task automatic do_bad(input logic [7:0] c);
        int r0;
        int w0;
        r0 = rd_cnt;
        w0 = wr_cnt;
        cs = 1'b0;
        hold();
        nib(c[7:4]);
        nib(c[3:0]);
        mode = 1'b1;
        for (int k = 0; k < 6; k++) nib(4'($urandom));
        end_txn();
        check("bad_cmd_strobes", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
    endtask

    task automatic check_nibs(input string name, input logic [15:0] w);
        check({name, "_len"}, 32'(got_q.size()), 32'd4);
        for (int k = 0; k < 4; k++) check(name, 32'(got_q[k]), 32'(w[15-4*k -: 4]));
    endtask

    initial begin
        ev_t         e;
        logic [7:0]  v;
        logic [15:0] a;
        int          w0;
        int          kind;
        int          n;

        for (int i = 0; i < 65536; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            ref_mem[i] = v;
        end
        mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
        mem[16'h1235] = 8'h3C; ref_mem[16'h1235] = 8'h3C;
        mem[16'hFFFF] = 8'h5A; ref_mem[16'hFFFF] = 8'h5A;
        mem[16'h0000] = 8'hC3; ref_mem[16'h0000] = 8'hC3;
        mem[16'h0020] = 8'h66; ref_mem[16'h0020] = 8'h66;

        fork
            forever begin
                @(posedge clk);
                if (mrd) mrdata <= mem[maddr];
                if (mwr) mem[maddr] <= mwdata;
            end
            forever begin
                @(negedge clk);
                if (mon_on && !rst) begin
                    if (mrd && mwr) check("rd_wr_overlap", 32'd1, 32'd0);
                    if (mrd || mwr) begin
                        if (mwr) wr_cnt++;
                        else     rd_cnt++;
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL unexpected_strobe: got wr=%0b addr=%0h, expected no strobe", mwr, maddr);
                        end else begin
                            e = exp_q.pop_front();
                            check("strobe_kind", 32'(mwr), 32'(e.wr));
                            check("strobe_addr", 32'(maddr), 32'(e.a));
                            if (e.wr) check("wr_data", 32'(mwdata), 32'(e.d));
                        end
                    end
                    if (!oe_allowed) check("oe_idle", 32'(oe), 32'd0);
                end
            end
        join_none

        repeat (2) @(negedge clk);
        check("reset_data", 32'(dout), 32'd0);
        check("reset_oe", 32'(oe), 32'd0);
        check("reset_rd", 32'(mrd), 32'd0);
        check("reset_wr", 32'(mwr), 32'd0);
        check("reset_addr", 32'(maddr), 32'd0);
        check("reset_wdata", 32'(mwdata), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mon_on = 1'b1;
        hold();

        do_read(16'h1234, 2, 1'b1, 1'b0);
        check_nibs("read_lit", 16'hA53C);

        w0 = wr_cnt;
        wq.push_back(8'h7E);
        wq.push_back(8'h91);
        do_write(16'h0010, 1'b0);
        check("write_count", 32'(wr_cnt - w0), 32'd2);
        check("write_mem0", 32'(mem[16'h0010]), 32'h7E);
        check("write_mem1", 32'(mem[16'h0011]), 32'h91);

        do_read(16'hFFFF, 2, 1'b1, 1'b0);
        check_nibs("wrap_lit", 16'h5AC3);

        w0 = wr_cnt;
        do_write(16'h0020, 1'b1);
        check("abort_count", 32'(wr_cnt - w0), 32'd0);
        do_read(16'h0020, 1, 1'b1, 1'b0);
        check("abort_keep_hi", 32'(got_q[0]), 32'h6);
        check("abort_keep_lo", 32'(got_q[1]), 32'h6);

        do_bad(8'hFF);

        for (int t = 0; t < 24; t++) begin
            kind = $urandom_range(0, 3);
            a = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFF - 16'($urandom_range(0, 2))) : 16'($urandom);
            n = $urandom_range(1, 3);
            case (kind)
                0: do_read(a, n, 1'($urandom_range(0, 1)), 1'b0);
                1: begin
                    for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
                    do_write(a, 1'b0);
                end
                2: begin
                    v = 8'($urandom);
                    if (v == 8'h02 || v == 8'h03) v = 8'hFF;
                    do_bad(v);
                end
                default: begin
                    for (int i = 0; i < n - 1; i++) wq.push_back(8'($urandom));
                    do_write(a, 1'b1);
                end
            endcase
        end

        do_read(16'h4000, 2, 1'b1, 1'b1);
        do_read(16'h1234, 2, 1'b1, 1'b0);
        check_nibs("restart_lit", 16'hA53C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
